// File: rtl/axi4l_reg_bridge.sv
// axi4l_reg_bridge: AXI4-Lite slave to single-outstanding req/ack register bus bridge.
// Ports: clk/rst (sync, active-high); s_aw*/s_w*/s_b* AXI4-Lite write channels;
// s_ar*/s_r* AXI4-Lite read channels; reg_* backend bus (req held until ack or timeout).
// Optional AXI4L_PROT_CHECK_EN: unprivileged in-window accesses get SLVERR without a bus cycle.
module axi4l_reg_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h4000_0000,
  parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0000_1000,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [2:0]          s_awprot,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [2:0]          s_arprot,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                reg_req,
  output logic                reg_we,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic                reg_ack,
  input  logic                reg_err,
  input  logic [DATA_W-1:0]   reg_rdata
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] WIN_M = ADDR_SIZE - 1'b1;
  localparam logic [ADDR_W-1:0] OFF_M = WIN_M & ({ADDR_W{1'b1}} << $clog2(SW));
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
`ifdef AXI4L_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WR_BUS, WR_RESP, RD_BUS, RD_RESP} state_t;
  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d, aw_priv_q, aw_priv_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [SW-1:0]       w_strb_q, w_strb_d;
  logic                prio_rd_q, prio_rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic                ar_hs, bus_ok;
  logic                unused_prot;
  // Base is aligned to the power-of-two size, so masking the offset bits decodes the window.
  function automatic logic hit(input logic [ADDR_W-1:0] a);
    return (a & ~WIN_M) == ADDR_BASE;
  endfunction
  function automatic logic deny(input logic priv);
    return PROT_EN && !priv;
  endfunction
  assign unused_prot = ^{s_awprot[2:1], s_arprot[2:1]};
  assign s_awready = !rst && state_q == IDLE && !aw_held_q;
  assign s_wready  = !rst && state_q == IDLE && !w_held_q;
  assign s_arready = !rst && state_q == IDLE && (!(aw_held_q && w_held_q) || prio_rd_q);
  assign ar_hs     = s_arvalid && s_arready;
  assign bus_ok    = reg_ack && !reg_err;
  always_comb begin
    state_d = state_q;
    aw_held_d = aw_held_q;
    w_held_d = w_held_q;
    aw_priv_d = aw_priv_q;
    aw_addr_d = aw_addr_q;
    w_data_d = w_data_q;
    w_strb_d = w_strb_q;
    prio_rd_d = prio_rd_q;
    cnt_d = cnt_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_awvalid && s_awready) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_awaddr;
          aw_priv_d = s_awprot[0];
        end
        if (s_wvalid && s_wready) begin
          w_held_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
        // A granted read wins; any half-captured write stays held for later.
        if (ar_hs) begin
          rdata_d = '0;
          rresp_d = hit(s_araddr) ? SLVERR : DECERR;
          if (hit(s_araddr) && !deny(s_arprot[0])) begin
            state_d = RD_BUS;
            req_d = 1'b1;
            we_d = 1'b0;
            addr_d = s_araddr & OFF_M;
          end else begin
            state_d = RD_RESP;
            rvalid_d = 1'b1;
          end
        end else if (aw_held_q && w_held_q) begin
          bresp_d = hit(aw_addr_q) ? SLVERR : DECERR;
          if (hit(aw_addr_q) && !deny(aw_priv_q)) begin
            state_d = WR_BUS;
            req_d = 1'b1;
            we_d = 1'b1;
            addr_d = aw_addr_q & OFF_M;
            wdata_d = w_data_q;
            wstrb_d = w_strb_q;
          end else begin
            state_d = WR_RESP;
            bvalid_d = 1'b1;
          end
        end
      end
      WR_BUS, RD_BUS: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so an ack on the final timeout cycle still counts.
        if (reg_ack || cnt_q == CW'(TIMEOUT - 1)) begin
          req_d = 1'b0;
          if (state_q == RD_BUS) begin
            state_d = RD_RESP;
            rvalid_d = 1'b1;
            rresp_d = bus_ok ? OKAY : SLVERR;
            rdata_d = reg_ack ? reg_rdata : '0;
          end else begin
            state_d = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d = bus_ok ? OKAY : SLVERR;
          end
        end
      end
      WR_RESP: if (s_bready) begin
        state_d = IDLE;
        bvalid_d = 1'b0;
        aw_held_d = 1'b0;
        w_held_d = 1'b0;
        prio_rd_d = 1'b1;
      end
      RD_RESP: if (s_rready) begin
        state_d = IDLE;
        rvalid_d = 1'b0;
        prio_rd_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      aw_priv_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      prio_rd_q <= 1'b0;
      cnt_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      aw_priv_q <= aw_priv_d;
      aw_addr_q <= aw_addr_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      prio_rd_q <= prio_rd_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
    end
  end
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign reg_req   = req_q;
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wstrb = wstrb_q;
endmodule

// File: tb/tb_axi4l_reg_bridge.sv
// tb_axi4l_reg_bridge: scoreboard bench for axi4l_reg_bridge with a delayed-ack backend model.
module tb_axi4l_reg_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 0, s_rready = 0;
  logic s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [31:0] s_awaddr = 0, s_araddr = 0, s_wdata = 0;
  logic [2:0] s_awprot = 3'b001, s_arprot = 3'b001;
  logic [3:0] s_wstrb = 0;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic reg_req, reg_we;
  logic [31:0] reg_addr, reg_wdata;
  logic [3:0] reg_wstrb;
  logic reg_ack = 0, reg_err = 0;
  logic [31:0] reg_rdata = 0;
  always #5 clk = ~clk;
  axi4l_reg_bridge dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; bit chk_w;} bus_t;
  typedef struct {bit rd; logic [1:0] resp; logic [31:0] data; bit bus;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t b;
  rsp_t r;
  int checks = 0, failures = 0;
  int ack_wait = 0;
  logic err_val = 0;
  logic [31:0] rd_val = 0;
  bit force_ack = 0;
  int req_cyc = 0, req_len = 0, last_req_len = 0;
  logic prev_req = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic void push_bus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit cw);
    bus_t x;
    x.we = we; x.addr = a; x.wdata = d; x.strb = s; x.chk_w = cw;
    bus_q.push_back(x);
  endfunction
  function automatic void push_rsp(input bit rd, input logic [1:0] resp, input logic [31:0] d, input bit bus);
    rsp_t x;
    x.rd = rd; x.resp = resp; x.data = d; x.bus = bus;
    rsp_q.push_back(x);
  endfunction
  // Backend: acks after ack_wait cycles of reg_req (never when negative).
  always @(negedge clk) begin
    if (reg_req) begin
      reg_ack = (req_cyc == ack_wait);
      reg_err = err_val;
      reg_rdata = rd_val;
      req_cyc++;
    end else begin
      reg_ack = force_ack;
      reg_err = 1'b0;
      req_cyc = 0;
    end
  end
  // Monitor: pops expected bus requests and responses as the DUT presents them.
  always @(negedge clk) begin
    if (reg_req && !prev_req) begin
      chk("req_expected", 32'(bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        b = bus_q.pop_front();
        chk("reg_we", 32'(reg_we), 32'(b.we));
        chk("reg_addr", reg_addr, b.addr);
        if (b.chk_w) begin
          chk("reg_wdata", reg_wdata, b.wdata);
          chk("reg_wstrb", 32'(reg_wstrb), 32'(b.strb));
        end
      end
    end
    if (reg_req) req_len++;
    else if (prev_req) begin
      last_req_len = req_len;
      req_len = 0;
    end
    if (s_bvalid && s_bready) begin
      chk("b_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("b_order", 32'(r.rd), 0);
        chk("bresp", 32'(s_bresp), 32'(r.resp));
        if (r.bus) chk("b_ack_lat", 32'(prev_req), 1);
      end
    end
    if (s_rvalid && s_rready) begin
      chk("r_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("r_order", 32'(r.rd), 1);
        chk("rresp", 32'(s_rresp), 32'(r.resp));
        chk("rdata", s_rdata, r.data);
        if (r.bus) chk("r_ack_lat", 32'(prev_req), 1);
      end
    end
    prev_req = reg_req;
  end
  task automatic hs(input bit aw, input bit w, input bit ar);
    int n = 0;
    bit ag, wg, rg;
    s_awvalid = aw; s_wvalid = w; s_arvalid = ar;
    while ((s_awvalid || s_wvalid || s_arvalid) && n < 200) begin
      ag = s_awvalid && s_awready;
      wg = s_wvalid && s_wready;
      rg = s_arvalid && s_arready;
      @(negedge clk);
      n++;
      if (ag) s_awvalid = 0;
      if (wg) s_wvalid = 0;
      if (rg) s_arvalid = 0;
    end
    chk("hs_in_time", 32'(n < 200), 1);
  endtask
  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 300), 1);
    @(negedge clk);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_wready", 32'(s_wready), 0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_bvalid", 32'(s_bvalid), 0);
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_bresp", 32'(s_bresp), 0);
    chk("rst_rresp", 32'(s_rresp), 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_req", 32'(reg_req), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_wstrb", 32'(reg_wstrb), 0);
    rst = 0; s_bready = 1; s_rready = 1;
    @(negedge clk);
    chk("idle_awready", 32'(s_awready), 1);
    chk("idle_arready", 32'(s_arready), 1);
    // basic write, ack after 2 cycles
    ack_wait = 2;
    wr(32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    push_bus(1, 32'h010, 32'hDEAD_BEEF, 4'hF, 1);
    push_rsp(0, 2'b00, 0, 1);
    hs(1, 1, 0);
    drain();
    chk("wr_req_len", last_req_len, 3);
    // minimum write latency with zero-wait ack, unaligned address
    ack_wait = 0;
    wr(32'h4000_0013, 32'h0BAD_F00D, 4'h6);
    push_bus(1, 32'h010, 32'h0BAD_F00D, 4'h6, 1);
    push_rsp(0, 2'b00, 0, 1);
    hs(1, 1, 0);
    n = 0;
    while (!s_bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_min_lat", n, 2);
    drain();
    // W three cycles ahead of AW
    wr(32'h4000_0020, 32'h1234_5678, 4'h3);
    push_bus(1, 32'h020, 32'h1234_5678, 4'h3, 1);
    push_rsp(0, 2'b00, 0, 1);
    hs(0, 1, 0);
    repeat (3) begin
      chk("w_only_noreq", 32'(reg_req), 0);
      @(negedge clk);
    end
    chk("w_held_wready", 32'(s_wready), 0);
    hs(1, 0, 0);
    drain();
    // out-of-window accesses
    rd_val = 32'hFFFF_FFFF;
    s_araddr = 32'h5000_0000;
    push_rsp(1, 2'b11, 0, 0);
    hs(0, 0, 1);
    drain();
    s_araddr = 32'h3FFF_FFFC;
    push_rsp(1, 2'b11, 0, 0);
    hs(0, 0, 1);
    drain();
    wr(32'h4000_1000, 32'h5555_5555, 4'hF);
    push_rsp(0, 2'b11, 0, 0);
    hs(1, 1, 0);
    drain();
    // read timeout, then a stray ack
    ack_wait = -1;
    rd_val = 32'hAAAA_5555;
    s_araddr = 32'h4000_0004;
    push_bus(0, 32'h004, 0, 0, 0);
    push_rsp(1, 2'b10, 0, 1);
    hs(0, 0, 1);
    drain();
    chk("timeout_req_len", last_req_len, 16);
    force_ack = 1;
    repeat (2) @(negedge clk);
    force_ack = 0;
    chk("stray_ack_req", 32'(reg_req), 0);
    chk("stray_ack_rvalid", 32'(s_rvalid), 0);
    repeat (2) @(negedge clk);
    // backend error on the last word of the window
    ack_wait = 1; err_val = 1;
    wr(32'h4000_0FFC, 32'h0F0F_0F0F, 4'hF);
    push_bus(1, 32'hFFC, 32'h0F0F_0F0F, 4'hF, 1);
    push_rsp(0, 2'b10, 0, 1);
    hs(1, 1, 0);
    drain();
    err_val = 0;
    // plain read leaves prio_rd = 0
    ack_wait = 0; rd_val = 32'h1111_2222;
    s_araddr = 32'h4000_0008;
    push_bus(0, 32'h008, 0, 0, 0);
    push_rsp(1, 2'b00, 32'h1111_2222, 1);
    hs(0, 0, 1);
    drain();
    // tie with prio_rd = 0: write first
    ack_wait = 1; rd_val = 32'h3434_3434;
    wr(32'h4000_0030, 32'h3030_3030, 4'hF);
    s_araddr = 32'h4000_0034;
    push_bus(1, 32'h030, 32'h3030_3030, 4'hF, 1);
    push_bus(0, 32'h034, 0, 0, 0);
    push_rsp(0, 2'b00, 0, 1);
    push_rsp(1, 2'b00, 32'h3434_3434, 1);
    hs(1, 1, 0);
    hs(0, 0, 1);
    drain();
    // a lone write sets prio_rd = 1
    wr(32'h4000_0040, 32'h4040_4040, 4'hF);
    push_bus(1, 32'h040, 32'h4040_4040, 4'hF, 1);
    push_rsp(0, 2'b00, 0, 1);
    hs(1, 1, 0);
    drain();
    // tie with prio_rd = 1: read first, held write afterwards
    rd_val = 32'h5454_5454;
    wr(32'h4000_0050, 32'h5050_5050, 4'hC);
    s_araddr = 32'h4000_0054;
    push_bus(0, 32'h054, 0, 0, 0);
    push_bus(1, 32'h050, 32'h5050_5050, 4'hC, 1);
    push_rsp(1, 2'b00, 32'h5454_5454, 1);
    push_rsp(0, 2'b00, 0, 1);
    hs(1, 1, 0);
    hs(0, 0, 1);
    drain();
    // reset while in RD_BUS
    ack_wait = -1;
    s_araddr = 32'h4000_0008;
    push_bus(0, 32'h008, 0, 0, 0);
    hs(0, 0, 1);
    @(negedge clk);
    chk("rd_bus_req", 32'(reg_req), 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_req", 32'(reg_req), 0);
    chk("midrst_rvalid", 32'(s_rvalid), 0);
    rst = 0;
    @(negedge clk);
    chk("postrst_rvalid", 32'(s_rvalid), 0);
    ack_wait = 0; rd_val = 32'hCAFE_F00D;
    s_araddr = 32'h4000_000C;
    push_bus(0, 32'h00C, 0, 0, 0);
    push_rsp(1, 2'b00, 32'hCAFE_F00D, 1);
    hs(0, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
